control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that sits directly upstream of the Datapath and drives its control inputs, replacing bench-driven stepping. It fetches an instruction, decodes ir[31:27] and sequences T-states at one step per clock. It samples the Datapath's con_out to resolve conditional branches. It supports the ld/ldi/st/ALU/addi/br/jr/in/out/nop/halt subset; remaining Datapath controls (hi/lo, zhi, pc_init) are tied off outside this block.

Parameters:
IR_WIDTH, 32, instruction register width; opcode is always ir[IR_WIDTH-1 -: 5].
ILLEGAL_HALTS, 0, 1 sends an undefined opcode to HALTED; 0 treats it as nop.

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
ir  in  IR_WIDTH  Datapath instruction register contents
con_out  in  1  Datapath branch-condition flag
stop  in  1  level request to pause at the next instruction boundary
pc_out  out  1  PC drives bus
zlo_out  out  1  Z low drives bus
mdr_out  out  1  MDR drives bus
inport_out  out  1  input port drives bus
c_sign_extended_out  out  1  sign-extended C field drives bus
r_out  out  1  selected GPR drives bus
ba_out  out  1  selected GPR drives bus, R0 reads as 0
gra  out  1  select Ra field
grb  out  1  select Rb field
grc  out  1  select Rc field
r_in  out  1  write selected GPR
pc_enable  out  1  load PC
pc_increment  out  1  ALU forced to PC+1
mar_enable  out  1  load MAR
mdr_enable  out  1  load MDR
read  out  1  MDR source is memory (0 = bus)
ram_write  out  1  memory write strobe
ir_enable  out  1  load IR
y_enable  out  1  load Y
z_enable  out  1  load Z
con_enable  out  1  load CON flip-flop
outport_enable  out  1  load output port
run  out  1  1 while executing (not RESET/STOPPED/HALTED)

Behaviour:
- Reset: async, clr=0 forces state RESET; all outputs 0 including run. On the first rising edge after clr rises, state moves to T0.
- Outputs are Moore signals decoded combinationally from state (and from the latched opcode in T3-T7). Each state lasts exactly 1 clk.
- Fetch, all instructions:
  - T0: pc_out, mar_enable, pc_increment, z_enable.
  - T1: zlo_out, pc_enable, read, mdr_enable.
  - T2: mdr_out, ir_enable.
- The opcode is taken from ir in T3 and held in an internal register for the rest of the instruction.
- Execute steps by opcode:
  - ld 00000: T3 grb, ba_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, mar_enable; T6 read, mdr_enable; T7 mdr_out, gra, r_in.
  - ldi 00001: T3 and T4 as ld; T5 zlo_out, gra, r_in.
  - st 00010: T3, T4 and T5 as ld; T6 gra, r_out, mdr_enable (read=0); T7 ram_write.
  - add 00011 / sub 00100 / and 00101 / or 00110: T3 grb, r_out, y_enable; T4 grc, r_out, z_enable; T5 zlo_out, gra, r_in. The Datapath derives the ALU op from ir.
  - addi 01100: T3 grb, r_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, gra, r_in.
  - br 10010: T3 gra, r_out, con_enable; T4 pc_out, y_enable; T5 c_sign_extended_out, z_enable; T6 zlo_out and pc_enable only if con_out=1, else all outputs 0. Target = (PC+1)+C; no extra increment.
  - jr 10011: T3 gra, r_out, pc_enable.
  - in 10110: T3 inport_out, gra, r_in.
  - out 10111: T3 gra, r_out, outport_enable.
  - nop 11010: T3 all outputs 0.
  - halt 11011: T3 all outputs 0, then HALTED.
- Instruction end: after the last listed step, the next state is T0, or STOPPED if stop=1 at that edge.
- stop is ignored mid-instruction. STOPPED: all outputs 0, run=0; returns to T0 on the first edge with stop=0.
- HALTED is absorbing until clr=0. All outputs 0, run=0.
- Undefined opcode: with ILLEGAL_HALTS=0, behaves as nop; with 1, behaves as halt.
- Reset mid-instruction: abandons the instruction immediately, all strobes drop asynchronously, no partial ram_write after release.
- con_out is sampled only in T6 of br. con_out toggling in other states has no effect.

Test Plan:
- Reset: clr=0 with ir=X, stop=0 -> all outputs 0, run=0. Release clr -> T0 on the next edge: pc_out=mar_enable=pc_increment=z_enable=1 for exactly 1 cycle.
- ldi: ir=0x08800005 (ldi R1,5) -> T0..T5 strobes per table, 6 cycles total. gra=r_in=zlo_out=1 in cycle 6 only. T0 reappears in cycle 7.
- br with con_out=1 in T6 -> zlo_out=pc_enable=1 in T6. Same br with con_out=0 -> T6 all outputs 0. Both complete in 7 cycles.
- st: ir opcode 00010 -> ram_write=1 in T7 only, with read=0 in T6. ld: read=1 and mdr_enable=1 in T6, r_in=1 in T7; 8 cycles each.
- stop: raise stop during T4 of add -> the instruction completes T5, then STOPPED with run=0. Drop stop -> T0 next edge. Separately, halt opcode -> HALTED with run=0 for 20+ cycles with no strobes.
- clr=0 asynchronously during T6 of st -> ram_write never asserts, outputs 0 within the same cycle. Undefined opcode 11111 with ILLEGAL_HALTS=0 -> T0 after T3; with ILLEGAL_HALTS=1 -> HALTED.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired T-state control unit driving the Datapath strobes.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int IR_WIDTH      = 32,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [IR_WIDTH-1:0] ir,
    input  logic                con_out,
    input  logic                stop,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                mdr_out,
    output logic                inport_out,
    output logic                c_sign_extended_out,
    output logic                r_out,
    output logic                ba_out,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                r_in,
    output logic                pc_enable,
    output logic                pc_increment,
    output logic                mar_enable,
    output logic                mdr_enable,
    output logic                read,
    output logic                ram_write,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                con_enable,
    output logic                outport_enable,
    output logic                run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // T3..T7 are consecutive so the execute phase can advance by increment.
    localparam logic [3:0] S_RESET   = 4'd0;
    localparam logic [3:0] S_T0      = 4'd1;
    localparam logic [3:0] S_T1      = 4'd2;
    localparam logic [3:0] S_T2      = 4'd3;
    localparam logic [3:0] S_T3      = 4'd4;
    localparam logic [3:0] S_T4      = 4'd5;
    localparam logic [3:0] S_T5      = 4'd6;
    localparam logic [3:0] S_T6      = 4'd7;
    localparam logic [3:0] S_T7      = 4'd8;
    localparam logic [3:0] S_STOPPED = 4'd9;
    localparam logic [3:0] S_HALTED  = 4'd10;

    logic [3:0] state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    logic [4:0] ir_op;
    logic [4:0] op;
    logic       is_alu, is_ld_group, is_multi, is_known;
    logic       halt_now, last_step;
    logic       ir_unused;

    assign ir_op     = ir[IR_WIDTH-1 -: 5];
    assign ir_unused = ^ir[IR_WIDTH-6:0];

    // In T3 the IR is decoded live; later steps use the latched copy.
    assign op = (state_q == S_T3) ? ir_op : opcode_q;

    assign is_alu      = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_ld_group = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign is_multi    = is_ld_group || is_alu || (op == OP_ADDI) || (op == OP_BR);
    assign is_known    = is_multi || (op == OP_JR) || (op == OP_IN) || (op == OP_OUT)
                       || (op == OP_NOP) || (op == OP_HALT);
    assign halt_now    = (state_q == S_T3)
                       && ((op == OP_HALT) || (!is_known && ILLEGAL_HALTS));

    always_comb begin
        last_step = 1'b0;
        case (state_q)
            S_T3:    last_step = !is_multi && !halt_now;
            S_T4:    last_step = !is_multi;
            S_T5:    last_step = !((op == OP_LD) || (op == OP_ST) || (op == OP_BR));
            S_T6:    last_step = !((op == OP_LD) || (op == OP_ST));
            S_T7:    last_step = 1'b1;
            default: last_step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_RESET;
            opcode_q <= OP_NOP;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = (state_q == S_T3) ? ir_op : opcode_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (halt_now)
                    state_d = S_HALTED;
                else if (last_step)
                    state_d = stop ? S_STOPPED : S_T0;
                else
                    state_d = state_q + 4'd1;
            end
            S_STOPPED: state_d = stop ? S_STOPPED : S_T0;
            S_HALTED:  state_d = S_HALTED;
            default:   state_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_out              = 1'b0;
        zlo_out             = 1'b0;
        mdr_out             = 1'b0;
        inport_out          = 1'b0;
        c_sign_extended_out = 1'b0;
        r_out               = 1'b0;
        ba_out              = 1'b0;
        gra                 = 1'b0;
        grb                 = 1'b0;
        grc                 = 1'b0;
        r_in                = 1'b0;
        pc_enable           = 1'b0;
        pc_increment        = 1'b0;
        mar_enable          = 1'b0;
        mdr_enable          = 1'b0;
        read                = 1'b0;
        ram_write           = 1'b0;
        ir_enable           = 1'b0;
        y_enable            = 1'b0;
        z_enable            = 1'b0;
        con_enable          = 1'b0;
        outport_enable      = 1'b0;
        run = (state_q != S_RESET) && (state_q != S_STOPPED) && (state_q != S_HALTED);

        case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                pc_enable  = 1'b1;
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_ld_group) begin
                    grb      = 1'b1;
                    ba_out   = 1'b1;
                    y_enable = 1'b1;
                end else if (is_alu || (op == OP_ADDI)) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (op == OP_BR) begin
                    gra        = 1'b1;
                    r_out      = 1'b1;
                    con_enable = 1'b1;
                end else if (op == OP_JR) begin
                    gra       = 1'b1;
                    r_out     = 1'b1;
                    pc_enable = 1'b1;
                end else if (op == OP_IN) begin
                    inport_out = 1'b1;
                    gra        = 1'b1;
                    r_in       = 1'b1;
                end else if (op == OP_OUT) begin
                    gra            = 1'b1;
                    r_out          = 1'b1;
                    outport_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_ld_group || (op == OP_ADDI)) begin
                    c_sign_extended_out = 1'b1;
                    z_enable            = 1'b1;
                end else if (is_alu) begin
                    grc      = 1'b1;
                    r_out    = 1'b1;
                    z_enable = 1'b1;
                end else if (op == OP_BR) begin
                    pc_out   = 1'b1;
                    y_enable = 1'b1;
                end
            end
            S_T5: begin
                if ((op == OP_LD) || (op == OP_ST)) begin
                    zlo_out    = 1'b1;
                    mar_enable = 1'b1;
                end else if ((op == OP_LDI) || is_alu || (op == OP_ADDI)) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (op == OP_BR) begin
                    c_sign_extended_out = 1'b1;
                    z_enable            = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    read       = 1'b1;
                    mdr_enable = 1'b1;
                end else if (op == OP_ST) begin
                    gra        = 1'b1;
                    r_out      = 1'b1;
                    mdr_enable = 1'b1;
                end else if ((op == OP_BR) && con_out) begin
                    zlo_out   = 1'b1;
                    pc_enable = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (op == OP_ST) begin
                    ram_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Directed vector bench for control_sequencer (both illegal modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [22:0] PCO  = 23'h1 << 22;
    localparam logic [22:0] ZLO  = 23'h1 << 21;
    localparam logic [22:0] MDRO = 23'h1 << 20;
    localparam logic [22:0] INP  = 23'h1 << 19;
    localparam logic [22:0] CSE  = 23'h1 << 18;
    localparam logic [22:0] RO   = 23'h1 << 17;
    localparam logic [22:0] BAO  = 23'h1 << 16;
    localparam logic [22:0] GRA  = 23'h1 << 15;
    localparam logic [22:0] GRB  = 23'h1 << 14;
    localparam logic [22:0] GRC  = 23'h1 << 13;
    localparam logic [22:0] RIN  = 23'h1 << 12;
    localparam logic [22:0] PCE  = 23'h1 << 11;
    localparam logic [22:0] PCI  = 23'h1 << 10;
    localparam logic [22:0] MARE = 23'h1 << 9;
    localparam logic [22:0] MDRE = 23'h1 << 8;
    localparam logic [22:0] RD   = 23'h1 << 7;
    localparam logic [22:0] RAMW = 23'h1 << 6;
    localparam logic [22:0] IRE  = 23'h1 << 5;
    localparam logic [22:0] YE   = 23'h1 << 4;
    localparam logic [22:0] ZE   = 23'h1 << 3;
    localparam logic [22:0] CONE = 23'h1 << 2;
    localparam logic [22:0] OUTE = 23'h1 << 1;
    localparam logic [22:0] RUN  = 23'h1;

    localparam logic [22:0] F0 = PCO | MARE | PCI | ZE | RUN;
    localparam logic [22:0] F1 = ZLO | PCE | RD | MDRE | RUN;
    localparam logic [22:0] F2 = MDRO | IRE | RUN;

    localparam logic [31:0] IR_ADD  = 32'h1800_0000;
    localparam logic [31:0] IR_ST   = 32'h1080_0010;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [7:0]  con;
        int          n;
        logic [22:0] s [8];
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        con_out;
    logic        stop;
    logic [31:0] ir;
    logic [22:0] oa, ob;
    logic        watch = 1'b0;
    logic        ram_seen = 1'b0;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    always @(oa[6]) if (watch && oa[6]) ram_seen = 1'b1;

    control_sequencer #(.IR_WIDTH(32), .ILLEGAL_HALTS(1'b0)) u_dut_a (
        .clk(clk), .clr(clr), .ir(ir), .con_out(con_out), .stop(stop),
        .pc_out(oa[22]), .zlo_out(oa[21]), .mdr_out(oa[20]), .inport_out(oa[19]),
        .c_sign_extended_out(oa[18]), .r_out(oa[17]), .ba_out(oa[16]),
        .gra(oa[15]), .grb(oa[14]), .grc(oa[13]), .r_in(oa[12]),
        .pc_enable(oa[11]), .pc_increment(oa[10]), .mar_enable(oa[9]),
        .mdr_enable(oa[8]), .read(oa[7]), .ram_write(oa[6]), .ir_enable(oa[5]),
        .y_enable(oa[4]), .z_enable(oa[3]), .con_enable(oa[2]),
        .outport_enable(oa[1]), .run(oa[0])
    );

    control_sequencer #(.IR_WIDTH(32), .ILLEGAL_HALTS(1'b1)) u_dut_b (
        .clk(clk), .clr(clr), .ir(ir), .con_out(con_out), .stop(stop),
        .pc_out(ob[22]), .zlo_out(ob[21]), .mdr_out(ob[20]), .inport_out(ob[19]),
        .c_sign_extended_out(ob[18]), .r_out(ob[17]), .ba_out(ob[16]),
        .gra(ob[15]), .grb(ob[14]), .grc(ob[13]), .r_in(ob[12]),
        .pc_enable(ob[11]), .pc_increment(ob[10]), .mar_enable(ob[9]),
        .mdr_enable(ob[8]), .read(ob[7]), .ram_write(ob[6]), .ir_enable(ob[5]),
        .y_enable(ob[4]), .z_enable(ob[3]), .con_enable(ob[2]),
        .outport_enable(ob[1]), .run(ob[0])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic void add_vec(input string nm, input logic [31:0] i, input logic [7:0] c,
                                    input int n, input logic [22:0] s3, input logic [22:0] s4,
                                    input logic [22:0] s5, input logic [22:0] s6,
                                    input logic [22:0] s7);
        vec_t v;
        v.name = nm;
        v.ir   = i;
        v.con  = c;
        v.n    = n;
        v.s[0] = F0;
        v.s[1] = F1;
        v.s[2] = F2;
        v.s[3] = s3 | RUN;
        v.s[4] = s4 | RUN;
        v.s[5] = s5 | RUN;
        v.s[6] = s6 | RUN;
        v.s[7] = s7 | RUN;
        vecs.push_back(v);
    endfunction

    // Leaves both DUTs 1 time unit past the edge that enters T0.
    task automatic do_reset(input string tag);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " reset a"}, {9'd0, oa}, 32'd0);
        chk({tag, " reset b"}, {9'd0, ob}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk({tag, " held until edge"}, {9'd0, oa}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [22:0] exp);
        @(negedge clk);
        chk(nm, {9'd0, oa}, {9'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [22:0] addseq [6];
        logic [22:0] stseq [8];

        add_vec("ldi",    32'h0880_0005, 8'h00, 6, GRB|BAO|YE, CSE|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("br_t",   32'h9080_0003, 8'h40, 7, GRA|RO|CONE, PCO|YE, CSE|ZE, ZLO|PCE, 0);
        add_vec("br_f",   32'h9080_0003, 8'hBF, 7, GRA|RO|CONE, PCO|YE, CSE|ZE, 0, 0);
        add_vec("st",     IR_ST,         8'h00, 8, GRB|BAO|YE, CSE|ZE, ZLO|MARE, GRA|RO|MDRE, RAMW);
        add_vec("ld",     32'h0080_0010, 8'h00, 8, GRB|BAO|YE, CSE|ZE, ZLO|MARE, RD|MDRE, MDRO|GRA|RIN);
        add_vec("add",    IR_ADD,        8'h00, 6, GRB|RO|YE, GRC|RO|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("sub",    32'h2000_0000, 8'hFF, 6, GRB|RO|YE, GRC|RO|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("and",    32'h2800_0000, 8'h00, 6, GRB|RO|YE, GRC|RO|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("or",     32'h3000_0000, 8'h00, 6, GRB|RO|YE, GRC|RO|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("addi",   32'h6000_0007, 8'h00, 6, GRB|RO|YE, CSE|ZE, ZLO|GRA|RIN, 0, 0);
        add_vec("jr",     32'h9800_0000, 8'h00, 4, GRA|RO|PCE, 0, 0, 0, 0);
        add_vec("in",     32'hB000_0000, 8'h00, 4, INP|GRA|RIN, 0, 0, 0, 0);
        add_vec("out",    32'hB800_0000, 8'h00, 4, GRA|RO|OUTE, 0, 0, 0, 0);
        add_vec("nop",    IR_NOP,        8'h00, 4, 0, 0, 0, 0, 0);
        add_vec("illegal",32'hF800_0000, 8'h00, 4, 0, 0, 0, 0, 0);

        addseq = '{F0, F1, F2, GRB|RO|YE|RUN, GRC|RO|ZE|RUN, ZLO|GRA|RIN|RUN};
        stseq  = '{F0, F1, F2, GRB|BAO|YE|RUN, CSE|ZE|RUN, ZLO|MARE|RUN,
                   GRA|RO|MDRE|RUN, RAMW|RUN};

        ir      = 'x;
        stop    = 1'b0;
        con_out = 1'b0;
        do_reset("init");

        foreach (vecs[k]) begin
            ir = vecs[k].ir;
            for (int c = 0; c < vecs[k].n; c++) begin
                con_out = vecs[k].con[c];
                step($sformatf("%s T%0d", vecs[k].name, c), vecs[k].s[c]);
            end
        end
        con_out = 1'b0;
        @(negedge clk);
        chk("illegal nop mode back to T0", {9'd0, oa}, {9'd0, F0});
        chk("illegal halt mode halted",    {9'd0, ob}, 32'd0);

        // stop raised mid-instruction only takes effect at the boundary
        do_reset("stop");
        ir = IR_ADD;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) stop = 1'b1;
            step($sformatf("stop add T%0d", c), addseq[c]);
        end
        for (int c = 0; c < 3; c++) step($sformatf("stopped %0d", c), 23'd0);
        stop = 1'b0;
        step("stopped until edge", 23'd0);
        step("resume T0", F0);

        // async clear during T6 of st must suppress the store
        do_reset("st_abort");
        ir    = IR_ST;
        watch = 1'b1;
        for (int c = 0; c < 6; c++) step($sformatf("st_abort T%0d", c), stseq[c]);
        @(negedge clk);
        chk("st_abort T6", {9'd0, oa}, {9'd0, stseq[6]});
        #2;
        clr = 1'b0;
        #1;
        chk("async clr drops strobes", {9'd0, oa}, 32'd0);
        ir = IR_NOP;
        @(posedge clk);
        #1;
        chk("clr low across edge", {9'd0, oa}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        chk("no ram_write after abort", {31'd0, ram_seen}, 32'd0);
        watch = 1'b0;

        // halt is absorbing regardless of stop/con_out activity
        do_reset("halt");
        ir = IR_HALT;
        step("halt T0", F0);
        step("halt T1", F1);
        step("halt T2", F2);
        step("halt T3", RUN);
        for (int c = 0; c < 22; c++) begin
            stop    = c[0];
            con_out = c[1];
            step($sformatf("halted %0d", c), 23'd0);
        end
        stop    = 1'b0;
        con_out = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
